// File: rtl/vector_pkg.sv
// Shared fixed-point container and pixel-scheduler types. Screen size defaults come from
// `SCREEN_WIDTH / `SCREEN_HEIGHT when the build does not define them.
`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 640
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 480
`endif

package vector_pkg;

  localparam int unsigned FRAC_BITS = 16;
  typedef logic signed [31:0] fp_t;

  // Credit counts are held in 8 bits, enough for up to 255 downstream FIFO slots.
  localparam int unsigned CREDIT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  function automatic int unsigned pixel_idx_w(input int unsigned w, input int unsigned h);
    int unsigned m;
    m = (w > h) ? w : h;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int unsigned PIXEL_IDX_W = pixel_idx_w(`SCREEN_WIDTH, `SCREEN_HEIGHT);

endpackage

// File: rtl/pixel_scheduler_credit_counter.sv
// Credit counter for the downstream ray FIFO: take on issue, give on consume; a give
// while already full saturates instead of wrapping.
module credit_counter
  import vector_pkg::*;
#(
  parameter int unsigned CREDITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                take,
  input  logic                give,
  output logic [CREDIT_W-1:0] count,
  output logic                has_credit,
  output logic                full
);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);

  logic [CREDIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (take && !give && has_credit) begin
      count_d = count_q - 1'b1;
    end else if (give && !take && !full) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= CREDIT_MAX;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign has_credit = (count_q != '0);
  assign full       = (count_q == CREDIT_MAX);

  // A return with every slot already free means downstream consumed a ray it never got.
  return_while_full: assert property (@(posedge clk) disable iff (!rst) !(give && full));

endmodule

// File: rtl/pixel_scheduler.sv
// Raster-order pixel issue with credit throttling towards the ray pipeline.
// Optional abort input is built in when PIXEL_SCHED_ABORT_EN is defined.
`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 640
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 480
`endif

// state | meaning
// IDLE  | waiting for start; x/y at 0
// RUN   | issuing one pixel per cycle while credits remain
// DRAIN | all pixels issued (or aborted); waiting for every credit to come back
module pixel_scheduler
  import vector_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = `SCREEN_WIDTH,
  parameter int unsigned SCREEN_HEIGHT = `SCREEN_HEIGHT,
  parameter int unsigned CREDITS       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic credit_return,
`ifdef PIXEL_SCHED_ABORT_EN
  input  logic abort,
`endif
  output fp_t  screen_x,
  output fp_t  screen_y,
  output logic coords_valid,
  output logic busy,
  output logic frame_done
);

  localparam int unsigned PIX_W = pixel_idx_w(SCREEN_WIDTH, SCREEN_HEIGHT);
  localparam logic [PIX_W-1:0] X_LAST = PIX_W'(SCREEN_WIDTH - 1);
  localparam logic [PIX_W-1:0] Y_LAST = PIX_W'(SCREEN_HEIGHT - 1);

  sched_state_t state_q, state_d;
  logic [PIX_W-1:0] x_q, x_d;
  logic [PIX_W-1:0] y_q, y_d;
  fp_t  screen_x_q, screen_x_d;
  fp_t  screen_y_q, screen_y_d;
  logic coords_valid_q, coords_valid_d;
  logic busy_q, busy_d;
  logic frame_done_q, frame_done_d;

  logic                issue;
  logic                has_credit;
  logic                credits_full;
  logic [CREDIT_W-1:0] credit_count;

  credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .take       (issue),
    .give       (credit_return),
    .count      (credit_count),
    .has_credit (has_credit),
    .full       (credits_full)
  );

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    screen_x_d     = screen_x_q;
    screen_y_d     = screen_y_q;
    coords_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    issue          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef PIXEL_SCHED_ABORT_EN
        if (abort) begin
          state_d = DRAIN;
        end else
`endif
        if (has_credit) begin
          // Decision uses the registered count; a same-cycle return only helps next cycle.
          issue          = 1'b1;
          coords_valid_d = 1'b1;
          screen_x_d     = fp_t'({{(32 - PIX_W){1'b0}}, x_q});
          screen_y_d     = fp_t'({{(32 - PIX_W){1'b0}}, y_q});
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = DRAIN;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (credits_full) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          x_d          = '0;
          y_d          = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      screen_x_q     <= '0;
      screen_y_q     <= '0;
      coords_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      screen_x_q     <= screen_x_d;
      screen_y_q     <= screen_y_d;
      coords_valid_q <= coords_valid_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign screen_x     = screen_x_q;
  assign screen_y     = screen_y_q;
  assign coords_valid = coords_valid_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler at W=4, H=3, CREDITS=2; abort scenario only when
// PIXEL_SCHED_ABORT_EN is defined.
module tb_pixel_scheduler;

  localparam int W = 4;
  localparam int H = 3;
  localparam int C = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        credit_return;
`ifdef PIXEL_SCHED_ABORT_EN
  logic        abort;
`endif
  logic [31:0] screen_x;
  logic [31:0] screen_y;
  logic        coords_valid;
  logic        busy;
  logic        frame_done;

  int   n_pass  = 0;
  int   n_total = 0;
  logic [2:0] echo_sr;
  bit   echo_en;

  pixel_scheduler #(
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .CREDITS       (C)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .credit_return (credit_return),
`ifdef PIXEL_SCHED_ABORT_EN
    .abort         (abort),
`endif
    .screen_x      (screen_x),
    .screen_y      (screen_y),
    .coords_valid  (coords_valid),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are stable 1 time unit after the edge. When echo is on,
  // each observed valid is returned as a credit three cycles later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (echo_en) begin
      credit_return = echo_sr[2];
      echo_sr = {echo_sr[1:0], coords_valid};
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    credit_return = 1'b0;
    echo_sr = '0;
    echo_en = 1'b0;
`ifdef PIXEL_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (coords_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", coords_valid); else n_pass++;
    n_total++; if (screen_x !== 32'd0 || screen_y !== 32'd0) $display("FAIL reset_xy got (%0d,%0d) want (0,0)", screen_x, screen_y); else n_pass++;
    n_total++; if (busy !== 1'b0 || frame_done !== 1'b0) $display("FAIL reset_busy_done got %0b/%0b want 0/0", busy, frame_done); else n_pass++;
    n_total++; if (dut.credit_count !== 8'(C)) $display("FAIL reset_credits got %0d want %0d", dut.credit_count, C); else n_pass++;
    repeat (3) tick();
    n_total++; if (coords_valid !== 1'b0 || busy !== 1'b0) $display("FAIL idle_no_start got valid=%0b busy=%0b want 0/0", coords_valid, busy); else n_pass++;
  endtask

  task automatic test_full_frame();
    int px, ex, ey;
    bit done;
    do_reset();
    echo_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL frame_busy_high got %0b want 1", busy); else n_pass++;
    px = 0; ex = 0; ey = 0; done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      tick();
      if (coords_valid) begin
        n_total++;
        if (screen_x !== 32'(ex) || screen_y !== 32'(ey))
          $display("FAIL frame_coord #%0d got (%0d,%0d) want (%0d,%0d)", px, screen_x, screen_y, ex, ey);
        else n_pass++;
        px++; ex++;
        if (ex == W) begin ex = 0; ey++; end
      end
      if (frame_done) done = 1'b1;
    end
    n_total++; if (!done) $display("FAIL frame_done_seen got 0 want 1 (timeout)"); else n_pass++;
    n_total++; if (px != W * H) $display("FAIL frame_pixel_count got %0d want %0d", px, W * H); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL frame_busy_at_done got %0b want 0", busy); else n_pass++;
    tick();
    n_total++; if (frame_done !== 1'b0) $display("FAIL frame_done_width got %0b want 0", frame_done); else n_pass++;
    n_total++; if (dut.credit_count !== 8'(C)) $display("FAIL frame_credits_back got %0d want %0d", dut.credit_count, C); else n_pass++;
  endtask

  task automatic test_credit_stall();
    int px;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    px = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (coords_valid) begin
        n_total++;
        if (screen_x !== 32'(px) || screen_y !== 32'd0)
          $display("FAIL stall_coord #%0d got (%0d,%0d) want (%0d,0)", px, screen_x, screen_y, px);
        else n_pass++;
        px++;
      end
    end
    n_total++; if (px != C) $display("FAIL stall_pixel_count got %0d want %0d", px, C); else n_pass++;
    n_total++; if (busy !== 1'b1 || dut.credit_count !== 8'd0) $display("FAIL stall_state got busy=%0b credits=%0d want 1/0", busy, dut.credit_count); else n_pass++;
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    n_total++; if (coords_valid !== 1'b0 || dut.credit_count !== 8'd1) $display("FAIL stall_return_latency got valid=%0b credits=%0d want 0/1", coords_valid, dut.credit_count); else n_pass++;
    tick();
    n_total++; if (coords_valid !== 1'b1 || screen_x !== 32'd2 || screen_y !== 32'd0) $display("FAIL stall_resume got valid=%0b (%0d,%0d) want 1 (2,0)", coords_valid, screen_x, screen_y); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int ex, ey;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_total++; if (coords_valid !== 1'b1 || screen_x !== 32'd0 || screen_y !== 32'd0) $display("FAIL simul_first got valid=%0b (%0d,%0d) want 1 (0,0)", coords_valid, screen_x, screen_y); else n_pass++;
    credit_return = 1'b1;
    for (int i = 1; i < W * H; i++) begin
      tick();
      ex = i % W; ey = i / W;
      n_total++;
      if (coords_valid !== 1'b1 || screen_x !== 32'(ex) || screen_y !== 32'(ey) || dut.credit_count !== 8'd1)
        $display("FAIL simul_issue #%0d got valid=%0b (%0d,%0d) credits=%0d want 1 (%0d,%0d) 1",
                 i, coords_valid, screen_x, screen_y, dut.credit_count, ex, ey);
      else n_pass++;
    end
    tick();
    credit_return = 1'b0;
    n_total++; if (coords_valid !== 1'b0 || busy !== 1'b1) $display("FAIL simul_drain got valid=%0b busy=%0b want 0/1", coords_valid, busy); else n_pass++;
    tick();
    n_total++; if (frame_done !== 1'b1) $display("FAIL simul_frame_done got %0b want 1", frame_done); else n_pass++;
  endtask

  task automatic test_start_handling();
    int px, px2;
    bit done;
    do_reset();
    echo_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    px = 0; done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      tick();
      start = 1'b0;
      if (coords_valid) begin
        px++;
        if (px == 5) start = 1'b1;
      end
      if (frame_done) done = 1'b1;
    end
    n_total++; if (!done || px != W * H) $display("FAIL start_in_run got done=%0b pixels=%0d want 1/%0d", done, px, W * H); else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL start_on_done_busy got %0b want 1", busy); else n_pass++;
    tick();
    n_total++; if (coords_valid !== 1'b1 || screen_x !== 32'd0 || screen_y !== 32'd0) $display("FAIL start_on_done_first got valid=%0b (%0d,%0d) want 1 (0,0)", coords_valid, screen_x, screen_y); else n_pass++;
    px2 = 1; done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      tick();
      if (coords_valid) px2++;
      if (frame_done) done = 1'b1;
    end
    n_total++; if (!done || px2 != W * H) $display("FAIL second_frame got done=%0b pixels=%0d want 1/%0d", done, px2, W * H); else n_pass++;
  endtask

  task automatic test_mid_frame_reset();
    bit found;
    do_reset();
    echo_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      tick();
      if (coords_valid && screen_x == 32'd2 && screen_y == 32'd1) found = 1'b1;
    end
    n_total++; if (!found) $display("FAIL reset_reach_21 got 0 want 1 (timeout)"); else n_pass++;
    rst = 1'b0;
    echo_sr = '0;
    credit_return = 1'b0;
    tick();
    n_total++;
    if (coords_valid !== 1'b0 || screen_x !== 32'd0 || screen_y !== 32'd0 || busy !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL midreset_outputs got valid=%0b (%0d,%0d) busy=%0b done=%0b want all 0",
               coords_valid, screen_x, screen_y, busy, frame_done);
    else n_pass++;
    n_total++; if (dut.credit_count !== 8'(C)) $display("FAIL midreset_credits got %0d want %0d", dut.credit_count, C); else n_pass++;
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_total++; if (coords_valid !== 1'b1 || screen_x !== 32'd0 || screen_y !== 32'd0) $display("FAIL midreset_restart got valid=%0b (%0d,%0d) want 1 (0,0)", coords_valid, screen_x, screen_y); else n_pass++;
  endtask

`ifdef PIXEL_SCHED_ABORT_EN
  task automatic test_abort();
    int px, extra;
    bit found, done;
    do_reset();
    echo_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    px = 0; found = 1'b0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      tick();
      if (coords_valid) begin
        px++;
        if (screen_x == 32'd1 && screen_y == 32'd1) found = 1'b1;
      end
    end
    n_total++; if (!found || px != 6) $display("FAIL abort_reach_11 got found=%0b pixels=%0d want 1/6", found, px); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    extra = coords_valid ? 1 : 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      tick();
      if (coords_valid) extra++;
      if (frame_done) done = 1'b1;
    end
    n_total++; if (extra != 0) $display("FAIL abort_no_issue got %0d extra pulses want 0", extra); else n_pass++;
    n_total++; if (!done || busy !== 1'b0) $display("FAIL abort_frame_done got done=%0b busy=%0b want 1/0", done, busy); else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_total++; if (coords_valid !== 1'b1 || screen_x !== 32'd0 || screen_y !== 32'd0) $display("FAIL abort_restart got valid=%0b (%0d,%0d) want 1 (0,0)", coords_valid, screen_x, screen_y); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_credit_stall();
    test_simultaneous();
    test_start_handling();
    test_mid_frame_reset();
`ifdef PIXEL_SCHED_ABORT_EN
    test_abort();
`endif
    do_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
